// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ifetch_pkg;

    localparam int unsigned IFETCH_WIDTH = 16;
    localparam int unsigned IFETCH_DEPTH = 4;

    // Encoding of "addnv reg0, reg0", presented when no instruction is available
    localparam logic [IFETCH_WIDTH-1:0] IFETCH_NOP = 16'h4000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [IFETCH_WIDTH-1:0] pc;
        logic [IFETCH_WIDTH-1:0] data;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch queue of {pc, data} entries; flush wins over push and pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = IFETCH_DEPTH
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   i_push,
    input  ifetch_entry_t          i_entry,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output ifetch_entry_t          o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifetch_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: streams words from a 1-cycle synchronous ROM into a small queue.
// Optional IFETCH_NOP_FILL_EN presents a NOP word whenever no instruction is available.
module instruction_prefetch
    import ifetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = IFETCH_WIDTH,
    parameter int unsigned      DEPTH    = IFETCH_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             nReset,
    output logic [WIDTH-1:0] ROMAddress,
    output logic             ROMReadEn,
    input  logic [WIDTH-1:0] ROMData,
    input  logic             redirectValid,
    input  logic [WIDTH-1:0] redirectAddr,
    input  logic             haltReq,
    output logic [WIDTH-1:0] instrData,
    output logic [WIDTH-1:0] instrPc,
    output logic             instrValid,
    input  logic             instrReady
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    ifetch_state_e    r_state;
    ifetch_state_e    w_state_nxt;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_resp_pc;
    logic [WIDTH-1:0] r_last_pc;
    logic             r_in_flight;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [OCC_W-1:0] w_occ;
    ifetch_entry_t    w_push_entry;
    ifetch_entry_t    w_head;

    // Slots already committed: queued entries plus the response still on its way
    assign w_occ = OCC_W'(w_count) + OCC_W'(r_in_flight);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) r_state <= ST_BOOT;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (haltReq) w_state_nxt = ST_HALT;
                else         w_issue = !redirectValid && !w_full && (w_occ < OCC_W'(DEPTH));
            end
            ST_HALT: begin
                if (!haltReq) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Fetch pointer, in-flight tracking and last presented pc
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_fetch_pc  <= RESET_PC;
            r_resp_pc   <= '0;
            r_last_pc   <= '0;
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_issue;
            if (w_issue) r_resp_pc <= r_fetch_pc;
            if (redirectValid) r_fetch_pc <= redirectAddr;
            else if (w_issue)  r_fetch_pc <= r_fetch_pc + WIDTH'(1);
            if (instrValid) r_last_pc <= WIDTH'(w_head.pc);
        end
    end

    assign ROMAddress   = r_fetch_pc;
    assign ROMReadEn    = w_issue;
    assign w_push       = r_in_flight && !redirectValid;
    assign w_push_entry = '{pc: IFETCH_WIDTH'(r_resp_pc), data: IFETCH_WIDTH'(ROMData)};
    assign instrValid   = !w_empty && !redirectValid;
    assign w_pop        = instrValid && instrReady;

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .nReset  (nReset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirectValid),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef IFETCH_NOP_FILL_EN
    logic w_fill;
    assign w_fill    = w_empty || redirectValid;
    assign instrData = w_fill ? WIDTH'(IFETCH_NOP) : WIDTH'(w_head.data);
    assign instrPc   = w_fill ? r_last_pc : WIDTH'(w_head.pc);
`else
    assign instrData = w_empty ? '0 : WIDTH'(w_head.data);
    assign instrPc   = w_empty ? r_last_pc : WIDTH'(w_head.pc);
`endif

endmodule
